// File: rtl/alu_pkg.sv
// Shared ALU opcode definitions, used by the ALU, the decoder and the issue controller.
// Opcodes are one-hot: exactly one of these bits is set for a legal op.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 19;

  localparam int unsigned OP_ADD   = 0;
  localparam int unsigned OP_SUB   = 1;
  localparam int unsigned OP_SLT   = 2;
  localparam int unsigned OP_SLTU  = 3;
  localparam int unsigned OP_AND   = 4;
  localparam int unsigned OP_NOR   = 5;
  localparam int unsigned OP_OR    = 6;
  localparam int unsigned OP_XOR   = 7;
  localparam int unsigned OP_SLL   = 8;
  localparam int unsigned OP_SRL   = 9;
  localparam int unsigned OP_SRA   = 10;
  localparam int unsigned OP_LUI   = 11;
  localparam int unsigned OP_MUL   = 12;
  localparam int unsigned OP_MULH  = 13;
  localparam int unsigned OP_MULHU = 14;
  localparam int unsigned OP_DIV   = 15;
  localparam int unsigned OP_DIVU  = 16;
  localparam int unsigned OP_MOD   = 17;
  localparam int unsigned OP_MODU  = 18;

  localparam logic [ALU_OP_W-1:0] MUL_MASK = 19'h0_7000;
  localparam logic [ALU_OP_W-1:0] DIV_MASK = 19'h7_8000;

  function automatic logic [ALU_OP_W-1:0] op_onehot(input int unsigned idx);
    logic [ALU_OP_W-1:0] one;
    one = 1;
    return one << idx;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Boundary of the execute-stage issue controller: decode handshake, ALU port and
// memory-stage handshake. The slave modport is the controller's view.
interface alu_issue_ctrl_if #(
  parameter int unsigned OP_W   = 19,
  parameter int unsigned DEST_W = 5
);
  logic              id_valid;
  logic              id_ready;
  logic [OP_W-1:0]   id_alu_op;
  logic [31:0]       id_src1;
  logic [31:0]       id_src2;
  logic [DEST_W-1:0] id_dest;
  logic [31:0]       id_pc;
  logic              flush;

  logic [OP_W-1:0]   alu_op;
  logic [31:0]       alu_src1;
  logic [31:0]       alu_src2;
  logic [31:0]       alu_result;
  logic              alu_complete;

  logic              ex_valid;
  logic              ex_ready;
  logic [31:0]       ex_result;
  logic [DEST_W-1:0] ex_dest;
  logic [31:0]       ex_pc;
  logic              busy;

  modport slave (
    input  id_valid, id_alu_op, id_src1, id_src2, id_dest, id_pc, flush,
    input  alu_result, alu_complete, ex_ready,
    output id_ready, alu_op, alu_src1, alu_src2, ex_valid, ex_result, ex_dest, ex_pc, busy
  );

  modport master (
    output id_valid, id_alu_op, id_src1, id_src2, id_dest, id_pc, flush,
    output alu_result, alu_complete, ex_ready,
    input  id_ready, alu_op, alu_src1, alu_src2, ex_valid, ex_result, ex_dest, ex_pc, busy
  );

endinterface

// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue controller: holds an op on the ALU until it completes, captures the
// result into an output register and enforces the mul/div issue contract.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned OP_W   = ALU_OP_W,
  parameter int unsigned DEST_W = 5
) (
  input  logic            clk,
  input  logic            resetn,
  alu_issue_ctrl_if.slave bus
);

  logic              op_valid_q, op_valid_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [31:0]       src1_q, src1_d;
  logic [31:0]       src2_q, src2_d;
  logic [DEST_W-1:0] op_dest_q, op_dest_d;
  logic [31:0]       op_pc_q, op_pc_d;

  logic              out_valid_q, out_valid_d;
  logic [31:0]       res_q, res_d;
  logic [DEST_W-1:0] out_dest_q, out_dest_d;
  logic [31:0]       out_pc_q, out_pc_d;

  logic can_take, fire, is_div, id_ready, accept;

  always_comb begin
    can_take = ~out_valid_q | bus.ex_ready;
    fire     = op_valid_q & bus.alu_complete & can_take & ~bus.flush;
    is_div   = |(op_q & OP_W'(DIV_MASK));
    // A completing divide never hands over directly: the divider must see one idle cycle.
    id_ready = ~bus.flush & (~op_valid_q | (fire & ~is_div));
    accept   = bus.id_valid & id_ready;
  end

  always_comb begin
    op_valid_d = op_valid_q;
    op_d       = op_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    op_dest_d  = op_dest_q;
    op_pc_d    = op_pc_q;
    if (bus.flush) begin
      op_valid_d = 1'b0;
    end else if (accept) begin
      op_valid_d = 1'b1;
      op_d       = bus.id_alu_op;
      src1_d     = bus.id_src1;
      src2_d     = bus.id_src2;
      op_dest_d  = bus.id_dest;
      op_pc_d    = bus.id_pc;
    end else if (fire) begin
      op_valid_d = 1'b0;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    res_d       = res_q;
    out_dest_d  = out_dest_q;
    out_pc_d    = out_pc_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (fire) begin
      out_valid_d = 1'b1;
      res_d       = bus.alu_result;
      out_dest_d  = op_dest_q;
      out_pc_d    = op_pc_q;
    end else if (out_valid_q && bus.ex_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_valid_q  <= 1'b0;
      op_q        <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      op_dest_q   <= '0;
      op_pc_q     <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      out_dest_q  <= '0;
      out_pc_q    <= '0;
    end else begin
      op_valid_q  <= op_valid_d;
      op_q        <= op_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      op_dest_q   <= op_dest_d;
      op_pc_q     <= op_pc_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      out_dest_q  <= out_dest_d;
      out_pc_q    <= out_pc_d;
    end
  end

  assign bus.id_ready  = id_ready;
  assign bus.alu_op    = (op_valid_q & ~bus.flush) ? op_q : '0;
  assign bus.alu_src1  = src1_q;
  assign bus.alu_src2  = src2_q;
  assign bus.ex_valid  = out_valid_q;
  assign bus.ex_result = res_q;
  assign bus.ex_dest   = out_dest_q;
  assign bus.ex_pc     = out_pc_q;
  assign bus.busy      = op_valid_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural ALU (2-cycle toggling mul,
// fixed-latency divider) attached to the ALU port.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int unsigned DW      = 5;
  localparam int unsigned DIV_LAT = 6;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   total = 0;
  int   bad = 0;

  alu_issue_ctrl_if #(.OP_W(ALU_OP_W), .DEST_W(DW)) bus ();

  alu_issue_ctrl #(.OP_W(ALU_OP_W), .DEST_W(DW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ALU
  logic        m_mul, m_div, mul_ph_q;
  logic [3:0]  div_cnt_q;
  logic [31:0] a, b, r;
  logic [63:0] prod_s, prod_u;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mul_ph_q  <= 1'b0;
      div_cnt_q <= '0;
    end else begin
      mul_ph_q <= m_mul ? ~mul_ph_q : 1'b0;
      if (!m_div) div_cnt_q <= '0;
      else if (div_cnt_q != 4'(DIV_LAT - 1)) div_cnt_q <= div_cnt_q + 4'd1;
    end
  end

  always_comb begin
    m_mul  = |(bus.alu_op & MUL_MASK);
    m_div  = |(bus.alu_op & DIV_MASK);
    a      = bus.alu_src1;
    b      = bus.alu_src2;
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'b0, a} * {32'b0, b};
    r      = '0;
    case (1'b1)
      bus.alu_op[OP_ADD]:   r = a + b;
      bus.alu_op[OP_SUB]:   r = a - b;
      bus.alu_op[OP_SLT]:   r = {31'b0, $signed(a) < $signed(b)};
      bus.alu_op[OP_SLTU]:  r = {31'b0, a < b};
      bus.alu_op[OP_AND]:   r = a & b;
      bus.alu_op[OP_NOR]:   r = ~(a | b);
      bus.alu_op[OP_OR]:    r = a | b;
      bus.alu_op[OP_XOR]:   r = a ^ b;
      bus.alu_op[OP_SLL]:   r = a << b[4:0];
      bus.alu_op[OP_SRL]:   r = a >> b[4:0];
      bus.alu_op[OP_SRA]:   r = $signed(a) >>> b[4:0];
      bus.alu_op[OP_LUI]:   r = {b[19:0], 12'b0};
      bus.alu_op[OP_MUL]:   r = prod_s[31:0];
      bus.alu_op[OP_MULH]:  r = prod_s[63:32];
      bus.alu_op[OP_MULHU]: r = prod_u[63:32];
      bus.alu_op[OP_DIV]:   r = (b == 0) ? '1 : $signed(a) / $signed(b);
      bus.alu_op[OP_DIVU]:  r = (b == 0) ? '1 : a / b;
      bus.alu_op[OP_MOD]:   r = (b == 0) ? a : $signed(a) % $signed(b);
      bus.alu_op[OP_MODU]:  r = (b == 0) ? a : a % b;
      default:              r = '0;
    endcase
    bus.alu_result   = r;
    bus.alu_complete = m_div ? (div_cnt_q == 4'(DIV_LAT - 1)) : (m_mul ? mul_ph_q : 1'b1);
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input bit v, input int unsigned idx, input logic [31:0] s1,
                          input logic [31:0] s2, input logic [DW-1:0] d, input logic [31:0] pc);
    bus.id_valid  = v;
    bus.id_alu_op = v ? op_onehot(idx) : '0;
    bus.id_src1   = s1;
    bus.id_src2   = s2;
    bus.id_dest   = d;
    bus.id_pc     = pc;
  endtask

  task automatic test_reset();
    #2;
    total++; if (bus.id_ready !== 1'b1) begin bad++; $display("FAIL rst_id_ready got=%b want=1", bus.id_ready); end
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL rst_ex_valid got=%b want=0", bus.ex_valid); end
    total++; if (bus.alu_op !== '0) begin bad++; $display("FAIL rst_alu_op got=%h want=0", bus.alu_op); end
    total++; if (bus.ex_result !== 32'd0) begin bad++; $display("FAIL rst_ex_result got=%h want=0", bus.ex_result); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
    @(negedge clk);
    resetn = 1'b1;
    next_cyc();
  endtask

  task automatic test_stream();
    bus.ex_ready = 1'b1;
    drive_op(1, OP_ADD, 32'd3, 32'd4, 5'd3, 32'h100);
    #2;
    total++; if (bus.id_ready !== 1'b1) begin bad++; $display("FAIL st_ready0 got=%b want=1", bus.id_ready); end
    next_cyc();
    drive_op(1, OP_SUB, 32'd10, 32'd3, 5'd4, 32'h104);
    #2;
    total++; if (bus.id_ready !== 1'b1) begin bad++; $display("FAIL st_ready1 got=%b want=1", bus.id_ready); end
    total++; if (bus.alu_op !== op_onehot(OP_ADD)) begin bad++; $display("FAIL st_alu_op got=%h want=%h", bus.alu_op, op_onehot(OP_ADD)); end
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL st_early got=%b want=0", bus.ex_valid); end
    next_cyc();
    drive_op(1, OP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd5, 32'h108);
    #2;
    total++; if (bus.ex_result !== 32'd7 || bus.ex_valid !== 1'b1) begin bad++; $display("FAIL st_res0 got=%0d/%b want=7/1", bus.ex_result, bus.ex_valid); end
    total++; if (bus.ex_dest !== 5'd3 || bus.ex_pc !== 32'h100) begin bad++; $display("FAIL st_tags got=%0d/%h want=3/100", bus.ex_dest, bus.ex_pc); end
    total++; if (bus.id_ready !== 1'b1) begin bad++; $display("FAIL st_ready2 got=%b want=1", bus.id_ready); end
    next_cyc();
    drive_op(0, 0, '0, '0, '0, '0);
    #2;
    total++; if (bus.ex_result !== 32'd7 || bus.ex_valid !== 1'b1) begin bad++; $display("FAIL st_res1 got=%0d/%b want=7/1", bus.ex_result, bus.ex_valid); end
    next_cyc();
    #2;
    total++; if (bus.ex_result !== 32'd1 || bus.ex_valid !== 1'b1) begin bad++; $display("FAIL st_res2 got=%0d/%b want=1/1", bus.ex_result, bus.ex_valid); end
    next_cyc();
    #2;
    total++; if (bus.ex_valid !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL st_drain got=%b/%b want=0/0", bus.ex_valid, bus.busy); end
  endtask

  task automatic test_mul();
    next_cyc();
    drive_op(1, OP_MUL, 32'h1_0000, 32'h1_0000, 5'd6, 32'h200);
    next_cyc();
    drive_op(1, OP_MULHU, 32'h1_0000, 32'h1_0000, 5'd7, 32'h204);
    #2;
    total++; if (bus.id_ready !== 1'b0) begin bad++; $display("FAIL mul_ready0 got=%b want=0", bus.id_ready); end
    total++; if (bus.alu_op !== op_onehot(OP_MUL)) begin bad++; $display("FAIL mul_alu_op got=%h want=%h", bus.alu_op, op_onehot(OP_MUL)); end
    next_cyc();
    #2;
    total++; if (bus.id_ready !== 1'b1) begin bad++; $display("FAIL mul_ready1 got=%b want=1", bus.id_ready); end
    next_cyc();
    drive_op(0, 0, '0, '0, '0, '0);
    #2;
    total++; if (bus.ex_result !== 32'd0 || bus.ex_valid !== 1'b1) begin bad++; $display("FAIL mul_res0 got=%h/%b want=0/1", bus.ex_result, bus.ex_valid); end
    next_cyc();
    #2;
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL mul_gap got=%b want=0", bus.ex_valid); end
    next_cyc();
    #2;
    total++; if (bus.ex_result !== 32'd1 || bus.ex_valid !== 1'b1) begin bad++; $display("FAIL mul_res1 got=%h/%b want=1/1", bus.ex_result, bus.ex_valid); end
    total++; if (bus.ex_dest !== 5'd7) begin bad++; $display("FAIL mul_dest got=%0d want=7", bus.ex_dest); end
  endtask

  task automatic test_div();
    int n;
    next_cyc();
    drive_op(1, OP_DIV, 32'd100, 32'd7, 5'd8, 32'h300);
    next_cyc();
    drive_op(1, OP_MOD, 32'd100, 32'd7, 5'd9, 32'h304);
    #2;
    n = 0;
    while (bus.ex_valid !== 1'b1 && n < 20) begin
      total++; if (bus.id_ready !== 1'b0) begin bad++; $display("FAIL div_ready_busy got=%b want=0", bus.id_ready); end
      next_cyc();
      #2;
      n++;
    end
    total++; if (bus.ex_result !== 32'd14 || n >= 20) begin bad++; $display("FAIL div_res got=%0d want=14 (waited %0d)", bus.ex_result, n); end
    total++; if (bus.alu_op !== '0) begin bad++; $display("FAIL div_idle got=%h want=0", bus.alu_op); end
    total++; if (bus.id_ready !== 1'b1) begin bad++; $display("FAIL div_ready_idle got=%b want=1", bus.id_ready); end
    next_cyc();
    drive_op(0, 0, '0, '0, '0, '0);
    #2;
    total++; if (bus.alu_op !== op_onehot(OP_MOD)) begin bad++; $display("FAIL mod_alu_op got=%h want=%h", bus.alu_op, op_onehot(OP_MOD)); end
    n = 0;
    while (bus.ex_valid !== 1'b1 && n < 20) begin
      next_cyc();
      #2;
      n++;
    end
    total++; if (bus.ex_result !== 32'd2 || n >= 20) begin bad++; $display("FAIL mod_res got=%0d want=2 (waited %0d)", bus.ex_result, n); end
  endtask

  task automatic test_backpressure();
    next_cyc();
    bus.ex_ready = 1'b0;
    drive_op(1, OP_ADD, 32'd5, 32'd5, 5'd10, 32'h400);
    next_cyc();
    drive_op(1, OP_ADD, 32'd1, 32'd2, 5'd11, 32'h404);
    #2;
    total++; if (bus.id_ready !== 1'b1) begin bad++; $display("FAIL bp_ready0 got=%b want=1", bus.id_ready); end
    next_cyc();
    drive_op(0, 0, '0, '0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      #2;
      total++; if (bus.ex_result !== 32'd10 || bus.ex_valid !== 1'b1) begin bad++; $display("FAIL bp_hold got=%0d/%b want=10/1", bus.ex_result, bus.ex_valid); end
      total++; if (bus.id_ready !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL bp_stall got=%b/%b want=0/1", bus.id_ready, bus.busy); end
      total++; if (bus.alu_op !== op_onehot(OP_ADD)) begin bad++; $display("FAIL bp_alu_op got=%h want=%h", bus.alu_op, op_onehot(OP_ADD)); end
      next_cyc();
    end
    bus.ex_ready = 1'b1;
    #2;
    total++; if (bus.ex_result !== 32'd10 || bus.ex_dest !== 5'd10) begin bad++; $display("FAIL bp_first got=%0d/%0d want=10/10", bus.ex_result, bus.ex_dest); end
    next_cyc();
    #2;
    total++; if (bus.ex_result !== 32'd3 || bus.ex_valid !== 1'b1 || bus.ex_dest !== 5'd11) begin bad++; $display("FAIL bp_second got=%0d/%b/%0d want=3/1/11", bus.ex_result, bus.ex_valid, bus.ex_dest); end
    next_cyc();
    #2;
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b want=0", bus.ex_valid); end
  endtask

  task automatic test_flush();
    next_cyc();
    drive_op(1, OP_DIVU, 32'hFFFF_FFFF, 32'd3, 5'd12, 32'h500);
    next_cyc();
    drive_op(0, 0, '0, '0, '0, '0);
    #2;
    total++; if (bus.alu_op !== op_onehot(OP_DIVU)) begin bad++; $display("FAIL fl_alu_op got=%h want=%h", bus.alu_op, op_onehot(OP_DIVU)); end
    next_cyc();
    next_cyc();
    next_cyc();
    bus.flush = 1'b1;
    drive_op(1, OP_ADD, 32'd1, 32'd1, 5'd13, 32'h504);
    #2;
    total++; if (bus.alu_op !== '0 || bus.id_ready !== 1'b0) begin bad++; $display("FAIL fl_cycle got=%h/%b want=0/0", bus.alu_op, bus.id_ready); end
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL fl_ex_valid0 got=%b want=0", bus.ex_valid); end
    next_cyc();
    bus.flush = 1'b0;
    #2;
    total++; if (bus.alu_op !== '0 || bus.busy !== 1'b0) begin bad++; $display("FAIL fl_after got=%h/%b want=0/0", bus.alu_op, bus.busy); end
    total++; if (bus.id_ready !== 1'b1 || bus.ex_valid !== 1'b0) begin bad++; $display("FAIL fl_ready got=%b/%b want=1/0", bus.id_ready, bus.ex_valid); end
    next_cyc();
    drive_op(0, 0, '0, '0, '0, '0);
    #2;
    total++; if (bus.alu_op !== op_onehot(OP_ADD) || bus.ex_valid !== 1'b0) begin bad++; $display("FAIL fl_add_issue got=%h/%b want=%h/0", bus.alu_op, bus.ex_valid, op_onehot(OP_ADD)); end
    next_cyc();
    #2;
    total++; if (bus.ex_result !== 32'd2 || bus.ex_valid !== 1'b1) begin bad++; $display("FAIL fl_add_res got=%0d/%b want=2/1", bus.ex_result, bus.ex_valid); end
  endtask

  task automatic test_async_reset();
    next_cyc();
    drive_op(1, OP_ADD, 32'd2, 32'd2, 5'd14, 32'h600);
    next_cyc();
    drive_op(1, OP_MUL, 32'd3, 32'd5, 5'd15, 32'h604);
    next_cyc();
    drive_op(0, 0, '0, '0, '0, '0);
    bus.ex_ready = 1'b0;
    #2;
    total++; if (bus.ex_valid !== 1'b1 || bus.busy !== 1'b1) begin bad++; $display("FAIL ar_pre got=%b/%b want=1/1", bus.ex_valid, bus.busy); end
    total++; if (bus.alu_op !== op_onehot(OP_MUL)) begin bad++; $display("FAIL ar_pre_op got=%h want=%h", bus.alu_op, op_onehot(OP_MUL)); end
    #1;
    resetn = 1'b0;
    #1;
    total++; if (bus.ex_valid !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL ar_state got=%b/%b want=0/0", bus.ex_valid, bus.busy); end
    total++; if (bus.alu_op !== '0 || bus.id_ready !== 1'b1) begin bad++; $display("FAIL ar_outs got=%h/%b want=0/1", bus.alu_op, bus.id_ready); end
    total++; if (bus.ex_result !== 32'd0) begin bad++; $display("FAIL ar_result got=%h want=0", bus.ex_result); end
    @(negedge clk);
    resetn = 1'b1;
    bus.ex_ready = 1'b1;
    next_cyc();
    #2;
    total++; if (bus.ex_valid !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL ar_post got=%b/%b want=0/0", bus.ex_valid, bus.busy); end
  endtask

  initial begin
    bus.flush    = 1'b0;
    bus.ex_ready = 1'b1;
    drive_op(0, 0, '0, '0, '0, '0);
    test_reset();
    test_stream();
    test_mul();
    test_div();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
